// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data-path widths, opcode encodings, IR field
// positions and the opcode-class decoder used by the decode stage.
package pipeline_pkg;

    localparam int REG_COUNT     = 16;
    localparam int REG_IDX_WIDTH = $clog2(REG_COUNT);
    localparam int DATA_WIDTH    = 16;
    localparam int PC_WIDTH      = 16;
    localparam int IR_WIDTH      = 32;
    localparam int OPCODE_WIDTH  = 8;

    // IR field positions (LSB of each field).
    localparam int OPCODE_LSB = 24;
    localparam int DEST_LSB   = 20;
    localparam int SRC1_LSB   = 16;
    localparam int SRC2_LSB   = 8;
    localparam int IMM_LSB    = 0;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 8'h00;
    localparam opcode_t OP_ADDI = 8'h01;
    localparam opcode_t OP_AND  = 8'h02;
    localparam opcode_t OP_ANDI = 8'h03;
    localparam opcode_t OP_MOV  = 8'h04;
    localparam opcode_t OP_MOVI = 8'h05;
    localparam opcode_t OP_LDW  = 8'h10;
    localparam opcode_t OP_STW  = 8'h11;
    localparam opcode_t OP_BRZ  = 8'h20;
    localparam opcode_t OP_BRN  = 8'h21;
    localparam opcode_t OP_JMP  = 8'h22;
    localparam opcode_t OP_NOP  = 8'hFF;

    typedef struct packed {
        logic defined;      // 0 for NOP and any undefined encoding
        logic reads_src1;
        logic reads_src2;   // for STW this is the data register in the dest field
        logic writes_dest;
        logic is_branch;
        logic is_store;
    } op_class_t;

    function automatic op_class_t op_class(input opcode_t op);
        op_class_t cls;
        // NOTE: every field gets a default before the case so no path leaves
        // anything unassigned; in an always_comb the same habit prevents latches.
        cls = '0;
        case (op)
            OP_ADD, OP_AND: begin
                cls.defined = 1'b1; cls.reads_src1 = 1'b1;
                cls.reads_src2 = 1'b1; cls.writes_dest = 1'b1;
            end
            OP_MOV, OP_ADDI, OP_ANDI, OP_LDW: begin
                cls.defined = 1'b1; cls.reads_src1 = 1'b1; cls.writes_dest = 1'b1;
            end
            OP_MOVI: begin
                cls.defined = 1'b1; cls.writes_dest = 1'b1;
            end
            OP_STW: begin
                cls.defined = 1'b1; cls.reads_src1 = 1'b1;
                cls.reads_src2 = 1'b1; cls.is_store = 1'b1;
            end
            OP_BRZ, OP_BRN: begin
                cls.defined = 1'b1; cls.reads_src1 = 1'b1; cls.is_branch = 1'b1;
            end
            OP_JMP: begin
                cls.defined = 1'b1; cls.is_branch = 1'b1;
            end
            default: cls = '0;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register file with per-register busy bits.
// Ports:
//   clk, rst            - falling-edge clock, async active-high reset
//   clear_busy          - synchronous clear of every busy bit (pipeline unlocked)
//   rd_idx1/rd_idx2     - read indices; rd_data1/rd_data2 are write-first values
//   rd_busy1/rd_busy2   - busy state of the read indices
//   dst_idx, dst_busy   - busy query for the destination register
//   set_en, set_idx     - mark a register busy (issued instruction writes it)
//   wb_en/wb_idx/wb_data- writeback: store data and release the busy bit
// Busy outputs already account for a same-edge writeback, so a register being
// written back this cycle reads as free and its read data is forwarded.
module reg_scoreboard
    import pipeline_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_busy,
    input  logic [REG_IDX_WIDTH-1:0] rd_idx1,
    input  logic [REG_IDX_WIDTH-1:0] rd_idx2,
    output logic [DATA_WIDTH-1:0]    rd_data1,
    output logic [DATA_WIDTH-1:0]    rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic [REG_IDX_WIDTH-1:0] dst_idx,
    output logic                     dst_busy,
    input  logic                     set_en,
    input  logic [REG_IDX_WIDTH-1:0] set_idx,
    input  logic                     wb_en,
    input  logic [REG_IDX_WIDTH-1:0] wb_idx,
    input  logic [DATA_WIDTH-1:0]    wb_data
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;

    logic hit1, hit2, hit_dst;

    assign hit1    = wb_en && (wb_idx == rd_idx1);
    assign hit2    = wb_en && (wb_idx == rd_idx2);
    assign hit_dst = wb_en && (wb_idx == dst_idx);

    assign rd_data1 = hit1 ? wb_data : regs[rd_idx1];
    assign rd_data2 = hit2 ? wb_data : regs[rd_idx2];
    assign rd_busy1 = busy[rd_idx1] & ~hit1;
    assign rd_busy2 = busy[rd_idx2] & ~hit2;
    assign dst_busy = busy[dst_idx] & ~hit_dst;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file must come out of reset cleared, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en) begin
                regs[wb_idx] <= wb_data;
            end
            if (clear_busy) begin
                busy <= '0;
            end else begin
                // NOTE: non-blocking updates to the same bit resolve to the last
                // one written, so the newer instruction's set beats the clear.
                if (wb_en) begin
                    busy[wb_idx] <= 1'b0;
                end
                if (set_en) begin
                    busy[set_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the FE/DE instruction, reads operands through the
// scoreboard, raises dependency/branch stalls to fetch and issues into DE/EX.
// Ports:
//   I_CLOCK, I_RESET            - falling-edge clock, async active-high reset
//   I_LOCK                      - pipeline enable (0 = idle, busy state cleared)
//   I_PC, I_IR, I_FetchStall    - FE/DE latch contents
//   I_WriteBack*                - register writeback
//   I_BranchResolved            - outstanding branch has resolved
//   O_LOCK, O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm,
//   O_DEStall                   - DE/EX latch
//   O_DepStallSignal, O_BranchStallSignal - combinational stalls to fetch
module decode_stage
    import pipeline_pkg::*;
(
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [IR_WIDTH-1:0]      I_IR,
    input  logic                     I_FetchStall,
    input  logic                     I_WriteBackEnable,
    input  logic [REG_IDX_WIDTH-1:0] I_WriteBackRegIdx,
    input  logic [DATA_WIDTH-1:0]    I_WriteBackData,
    input  logic                     I_BranchResolved,
    output logic                     O_LOCK,
    output logic [PC_WIDTH-1:0]      O_PC,
    output logic [OPCODE_WIDTH-1:0]  O_Opcode,
    output logic [REG_IDX_WIDTH-1:0] O_DestRegIdx,
    output logic [DATA_WIDTH-1:0]    O_Src1Value,
    output logic [DATA_WIDTH-1:0]    O_Src2Value,
    output logic [DATA_WIDTH-1:0]    O_Imm,
    output logic                     O_DepStallSignal,
    output logic                     O_BranchStallSignal,
    output logic                     O_DEStall
);

    opcode_t                  opcode;
    op_class_t                cls;
    logic [REG_IDX_WIDTH-1:0] dest_idx, src1_idx, src2_idx, rd2_idx;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    src1_value, src2_value;
    logic                     busy1, busy2, dest_busy;
    logic                     valid, dep_stall, issue;
    logic                     branch_pending;

    assign opcode   = I_IR[OPCODE_LSB +: OPCODE_WIDTH];
    assign dest_idx = I_IR[DEST_LSB +: REG_IDX_WIDTH];
    assign src1_idx = I_IR[SRC1_LSB +: REG_IDX_WIDTH];
    assign src2_idx = I_IR[SRC2_LSB +: REG_IDX_WIDTH];
    assign imm      = I_IR[IMM_LSB +: DATA_WIDTH];
    assign cls      = op_class(opcode);

    // A store's data register lives in the dest field and leaves on port 2.
    assign rd2_idx = cls.is_store ? dest_idx : src2_idx;

    // Reset gates valid so both stalls drop the moment reset rises.
    assign valid     = ~I_RESET & I_LOCK & ~I_FetchStall & cls.defined;
    assign dep_stall = valid & ((cls.reads_src1  & busy1) |
                                (cls.reads_src2  & busy2) |
                                (cls.writes_dest & dest_busy));
    assign issue     = valid & ~dep_stall & ~branch_pending;

    assign O_DepStallSignal    = dep_stall;
    assign O_BranchStallSignal = branch_pending | (valid & cls.is_branch & ~dep_stall);

    reg_scoreboard u_scoreboard (
        .clk        (I_CLOCK),
        .rst        (I_RESET),
        .clear_busy (~I_LOCK),
        .rd_idx1    (src1_idx),
        .rd_idx2    (rd2_idx),
        .rd_data1   (src1_value),
        .rd_data2   (src2_value),
        .rd_busy1   (busy1),
        .rd_busy2   (busy2),
        .dst_idx    (dest_idx),
        .dst_busy   (dest_busy),
        .set_en     (issue & cls.writes_dest),
        .set_idx    (dest_idx),
        .wb_en      (I_WriteBackEnable),
        .wb_idx     (I_WriteBackRegIdx),
        .wb_data    (I_WriteBackData)
    );

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            O_LOCK         <= 1'b0;
            O_PC           <= '0;
            O_Opcode       <= OP_NOP;
            O_DestRegIdx   <= '0;
            O_Src1Value    <= '0;
            O_Src2Value    <= '0;
            O_Imm          <= '0;
            O_DEStall      <= 1'b1;
            branch_pending <= 1'b0;
        end else begin
            O_LOCK <= I_LOCK;
            if (!I_LOCK) begin
                O_DEStall      <= 1'b1;
                O_Opcode       <= OP_NOP;
                branch_pending <= 1'b0;
            end else if (issue) begin
                O_PC           <= I_PC;
                O_Opcode       <= opcode;
                O_DestRegIdx   <= dest_idx;
                O_Src1Value    <= src1_value;
                O_Src2Value    <= src2_value;
                O_Imm          <= imm;
                O_DEStall      <= 1'b0;
                branch_pending <= cls.is_branch;
            end else begin
                // Bubble: only the opcode and the bubble flag change.
                O_DEStall <= 1'b1;
                O_Opcode  <= OP_NOP;
                if (I_BranchResolved) begin
                    branch_pending <= 1'b0;
                end
            end
        end
    end

endmodule
